button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumes the debounced level `db` from the switch debouncer, on the same clock domain.
- Classifies each press into one of three one-cycle event pulses: short press, long press, or double click.
- Provides a `held` level while a long press continues, and a running count of presses.
- Sits between the debouncer and the control/display logic that reacts to button events.

Parameters:
- TICK_DIV, 50000: clk cycles per millisecond tick (50 MHz clock).
- LONG_MS, 1000: press duration in ms that qualifies as a long press.
- DCLICK_MS, 300: maximum release gap in ms before a second press; also the short-press confirmation delay.
- CW, 16: width of the ms counter; must satisfy 2^CW > max(LONG_MS, DCLICK_MS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- db  in  1  debounced button level, synchronous to clk.
- short_pulse  out  1  one-cycle pulse: single short press confirmed.
- long_pulse  out  1  one-cycle pulse: press held for LONG_MS.
- double_pulse  out  1  one-cycle pulse: second press started within DCLICK_MS of a release.
- held  out  1  high while in LONG_HOLD.
- press_count  out  8  number of db rising edges accepted from IDLE or RELEASE1; wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; prescaler and ms counter clear.
  - All outputs are 0, including press_count.
- Prescaler:
  - Counts 0..TICK_DIV-1; `tick` is high combinationally when prescaler == TICK_DIV-1.
  - Prescaler and ms counter both clear on every state change.
  - ms counter increments on tick and saturates at 2^CW-1.
  - `timeout(X)` = tick AND ms_cnt == X-1.
  - Net effect: a timeout fires exactly X*TICK_DIV edges after the transition edge.
- States: IDLE, PRESS1, RELEASE1, PRESS2, LONG_HOLD.
  - IDLE: db=1 -> PRESS1; press_count++.
  - PRESS1:
    - db=0 -> RELEASE1.
    - else timeout(LONG_MS) -> LONG_HOLD, with long_pulse.
  - RELEASE1:
    - db=1 -> PRESS2, with double_pulse; press_count++.
    - else timeout(DCLICK_MS) -> IDLE, with short_pulse.
  - PRESS2: db=0 -> IDLE. No timeout; a long second press produces no long_pulse.
  - LONG_HOLD: held=1; db=0 -> IDLE.
- Outputs:
  - All outputs are registered.
  - Each pulse is high for exactly the one cycle following the transition edge that generated it.
  - held is 1 in the cycle after entry to LONG_HOLD and 0 in the cycle after leaving it.
- Priority: if a db change and a timeout occur in the same cycle, the db change wins.
  - Example: in PRESS1, a release at the long threshold gives RELEASE1 and no long_pulse.
- Mutual exclusion: at most one of the three pulses is high in any cycle.
- Mid-operation reset: aborts any pending classification; no pulse is emitted for it.
- After reset release:
  - If db=1 on the first clock, this counts as a new press and goes to PRESS1.
  - No other special handling.
- Unreachable state encodings return to IDLE on the next clock.

Decomposition:
- Shared package `button_pkg`:
  - State encoding localparams (3-bit).
  - The 50 MHz constant from which TICK_DIV is derived.
- One natural sub-module, `ms_tick_gen`:
  - Holds the prescaler plus the saturating ms counter.
  - Inputs: clk, reset, clr.
  - Outputs: tick, ms_cnt.
- The FSM and output registers stay in the top module.

Test Plan:
- Bench configuration for all scenarios: TICK_DIV=4, LONG_MS=10, DCLICK_MS=5.
- Scenario 1: db rises at edge 0 and is held -> long_pulse high for the single cycle after edge 40; held=1 from edge 40 until release; no short or double pulse; press_count=1.
- Scenario 2: db high on edges 0..11, release sampled at edge 12 -> short_pulse one cycle after edge 32; nothing else fires; press_count=1.
- Scenario 3: press at edge 0, release at edge 8, second press at edge 16 -> double_pulse one cycle after edge 16; release then returns to IDLE with no short_pulse; press_count=2.
- Scenario 4: release sampled on exactly the edge where PRESS1 would time out (edge 40) -> state RELEASE1, no long_pulse; short_pulse after edge 60.
- Scenario 5: reset driven low while in RELEASE1 (edge 15) -> all outputs 0 immediately; no short_pulse at the old edge 35; press_count=0.
- Scenario 6: 256 short presses, each separated by more than 20 idle cycles -> 256 short_pulses; press_count wraps to 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants for the button event decoder: state encodings and the
// clock-rate constant the millisecond prescaler is derived from.
package button_pkg;

  // System clock frequency and the resulting clk cycles per 1 ms tick.
  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned MS_PER_S         = 1000;
  localparam int unsigned TICK_DIV_DEFAULT = CLK_HZ / MS_PER_S;

  // 3-bit state encodings; the three remaining codes are unreachable.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_RELEASE1  = 3'd2;
  localparam logic [2:0] ST_PRESS2    = 3'd3;
  localparam logic [2:0] ST_LONG_HOLD = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    PRESS1    = ST_PRESS1,
    RELEASE1  = ST_RELEASE1,
    PRESS2    = ST_PRESS2,
    LONG_HOLD = ST_LONG_HOLD
  } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond time base: a prescaler that produces a one-cycle tick every
// TICK_DIV clocks, and a saturating count of ticks since the last clear.
// clr restarts both so a timeout lands a whole number of ms after it.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          tick,
  output logic [CW-1:0] ms_cnt
);

  localparam int unsigned   PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] MS_MAX  = '1;

  logic [PW-1:0] pre_reg;
  logic [CW-1:0] ms_reg;

  assign tick   = (pre_reg == PRE_MAX);
  assign ms_cnt = ms_reg;

  // Prescaler: counts 0..TICK_DIV-1, wrapping on tick, restarting on clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_reg <= '0;
    end else if (clr || tick) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_reg + PW'(1);
    end
  end

  // ms counter: advances once per tick and sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_reg <= '0;
    end else if (clr) begin
      ms_reg <= '0;
    end else if (tick && (ms_reg != MS_MAX)) begin
      ms_reg <= ms_reg + CW'(1);
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short / long / double-click
// pulses, drives a held level during a long press and counts presses.
// All outputs are registered; a button change beats a coincident timeout.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned CW        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  // Last ms count before the qualifying tick of each timeout.
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_MS - 1);

  state_t        state_reg;
  state_t        state_next;
  logic          tick;
  logic [CW-1:0] ms_cnt;
  logic          clr;
  logic          long_to;
  logic          dclick_to;
  logic          short_next;
  logic          long_next;
  logic          double_next;
  logic          count_inc;

  logic          short_reg;
  logic          long_reg;
  logic          double_reg;
  logic          held_reg;
  logic [7:0]    press_count_reg;

  // Any state change restarts the time base on the same edge, so each
  // timeout is measured from the transition that entered the state.
  assign clr       = (state_next != state_reg);
  assign long_to   = tick && (ms_cnt == LONG_LAST);
  assign dclick_to = tick && (ms_cnt == DCLICK_LAST);

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CW       (CW)
  ) u_ms_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .tick   (tick),
    .ms_cnt (ms_cnt)
  );

  // Next-state and event decode; db tests come first so they win over timeouts.
  always_comb begin
    state_next  = state_reg;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    count_inc   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (db) begin
          state_next = PRESS1;
          count_inc  = 1'b1;
        end
      end
      PRESS1: begin
        if (!db) begin
          state_next = RELEASE1;
        end else if (long_to) begin
          state_next = LONG_HOLD;
          long_next  = 1'b1;
        end
      end
      RELEASE1: begin
        if (db) begin
          state_next  = PRESS2;
          double_next = 1'b1;
          count_inc   = 1'b1;
        end else if (dclick_to) begin
          state_next = IDLE;
          short_next = 1'b1;
        end
      end
      PRESS2: begin
        if (!db) begin
          state_next = IDLE;
        end
      end
      LONG_HOLD: begin
        if (!db) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus registered pulses, held level and press counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      short_reg       <= 1'b0;
      long_reg        <= 1'b0;
      double_reg      <= 1'b0;
      held_reg        <= 1'b0;
      press_count_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      short_reg  <= short_next;
      long_reg   <= long_next;
      double_reg <= double_next;
      held_reg   <= (state_next == LONG_HOLD);
      if (count_inc) begin
        press_count_reg <= press_count_reg + 8'd1;
      end
    end
  end

  assign short_pulse  = short_reg;
  assign long_pulse   = long_reg;
  assign double_pulse = double_reg;
  assign held         = held_reg;
  assign press_count  = press_count_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder (TICK_DIV=4, LONG_MS=10,
// DCLICK_MS=5). Stimulus is a per-edge db waveform; a press-level model
// turns runs of 1s into expected events, which a negedge monitor checks.
module tb_button_event_decoder;

  localparam int TD = 4;
  localparam int LT = TD * 10;   // long threshold in edges
  localparam int DT = TD * 5;    // double-click window / short delay in edges

  typedef struct {
    int kind;   // 0 short, 1 long, 2 double
    int at;     // absolute edge index after which the pulse is high
  } ev_t;

  logic       clk;
  logic       reset;
  logic       db;
  logic       short_pulse;
  logic       long_pulse;
  logic       double_pulse;
  logic       held;
  logic [7:0] press_count;

  int  checks;
  int  failures;
  int  edge_cnt;
  int  model_cnt;
  int  short_seen;
  int  hbase;
  int  hlen;
  bit  hexp[];
  bit  wave_q[$];
  ev_t sb_q[$];

  button_event_decoder #(
    .TICK_DIV  (4),
    .LONG_MS   (10),
    .DCLICK_MS (5),
    .CW        (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .db           (db),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .double_pulse (double_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic string kname(input int k);
    if (k == 0) return "short";
    if (k == 1) return "long";
    return "double";
  endfunction

  // Monitor: pulses pop the scoreboard; held is compared every cycle.
  always @(negedge clk) begin
    int e;
    int n;
    int k;
    bit hx;
    ev_t ev;
    e = edge_cnt - 1;
    n = int'(short_pulse) + int'(long_pulse) + int'(double_pulse);
    checks++;
    if (n > 1) begin
      failures++;
      $display("FAIL mutex edge=%0d got short=%0b long=%0b double=%0b want at most one",
               e, short_pulse, long_pulse, double_pulse);
    end
    if (n >= 1) begin
      k = short_pulse ? 0 : (long_pulse ? 1 : 2);
      if (k == 0) short_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got %s at edge %0d want none", kname(k), e);
      end else begin
        ev = sb_q.pop_front();
        if (ev.kind != k || ev.at != e) begin
          failures++;
          $display("FAIL event got %s at edge %0d want %s at edge %0d",
                   kname(k), e, kname(ev.kind), ev.at);
        end else begin
          $display("event %s at edge %0d count=%0d", kname(k), e, press_count);
        end
      end
    end
    hx = (hlen > 0 && e >= hbase && e < hbase + hlen) ? hexp[e - hbase] : 1'b0;
    checks++;
    if (held !== hx) begin
      failures++;
      $display("FAIL held edge=%0d got %0b want %0b", e, held, hx);
    end
  end

  task automatic add(input bit v, input int n);
    for (int i = 0; i < n; i++) wave_q.push_back(v);
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_short"}, int'(short_pulse), 0);
    check_val({tag, "_long"}, int'(long_pulse), 0);
    check_val({tag, "_double"}, int'(double_pulse), 0);
    check_val({tag, "_held"}, int'(held), 0);
    check_val({tag, "_count"}, int'(press_count), 0);
  endtask

  // Press-level reference: each run of 1s is a press; classify by length and
  // by the gap to the following press, then drive the waveform.
  task automatic run_wave(input string name);
    int rise_q[$];
    int fall_q[$];
    int base;
    int i;
    int s;
    int f;
    ev_t ev;
    add(1'b0, 30);
    for (int k = 0; k < wave_q.size(); k++) begin
      if (wave_q[k] && (k == 0 || !wave_q[k-1])) rise_q.push_back(k);
      if (!wave_q[k] && k > 0 && wave_q[k-1]) fall_q.push_back(k);
    end
    base  = edge_cnt;
    hexp  = new[wave_q.size()];
    for (int k = 0; k < wave_q.size(); k++) hexp[k] = 1'b0;
    hbase = base;
    hlen  = wave_q.size();
    i = 0;
    while (i < rise_q.size()) begin
      s = rise_q[i];
      f = fall_q[i];
      model_cnt++;
      if (f - s > LT) begin
        ev.kind = 1; ev.at = base + s + LT; sb_q.push_back(ev);
        for (int k = s + LT; k < f; k++) hexp[k] = 1'b1;
        i++;
      end else if (i + 1 < rise_q.size() && rise_q[i+1] <= f + DT) begin
        ev.kind = 2; ev.at = base + rise_q[i+1]; sb_q.push_back(ev);
        model_cnt++;
        i += 2;
      end else begin
        ev.kind = 0; ev.at = base + f + DT; sb_q.push_back(ev);
        i++;
      end
    end
    for (int k = 0; k < wave_q.size(); k++) begin
      db = wave_q[k];
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    check_val({name, "_pending_events"}, sb_q.size(), 0);
    check_val({name, "_press_count"}, int'(press_count), model_cnt % 256);
    $display("scenario %s done count=%0d", name, press_count);
    sb_q.delete();
    wave_q.delete();
    hlen = 0;
  endtask

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      db = v;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int lo;
    checks     = 0;
    failures   = 0;
    edge_cnt   = 0;
    model_cnt  = 0;
    short_seen = 0;
    hlen       = 0;
    hbase      = 0;
    db         = 1'b0;
    reset      = 1'b0;

    // Reset state.
    #22;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 3);

    // 1: held long press.
    add(1'b1, 50);
    run_wave("long_hold");

    // 2: short press.
    add(1'b1, 12);
    run_wave("short");

    // 3: double click.
    add(1'b1, 8); add(1'b0, 8); add(1'b1, 6);
    run_wave("double");

    // 4: release exactly at the long threshold.
    add(1'b1, 40);
    run_wave("release_at_threshold");

    // 5: reset while waiting in RELEASE1.
    hlen = 0;
    drive(1'b1, 15);
    drive(1'b0, 6);
    check_val("pre_reset_count", int'(press_count), (model_cnt + 1) % 256);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    drive(1'b0, 30);
    check_all_zero("held_reset");
    reset = 1'b1;
    model_cnt = 0;
    drive(1'b0, 3);
    check_val("post_reset_count", int'(press_count), 0);
    $display("scenario mid_reset done count=%0d", press_count);

    // 6: 256 short presses, count wraps back to 0.
    short_seen = 0;
    for (int p = 0; p < 256; p++) begin
      hi = int'($urandom_range(1, 40));
      lo = int'($urandom_range(21, 30));
      add(1'b1, hi);
      add(1'b0, lo);
    end
    run_wave("wrap256");
    check_val("wrap256_shorts", short_seen, 256);
    check_val("wrap256_count_zero", int'(press_count), 0);

    // 7: random mix of shorts, longs and double clicks.
    for (int p = 0; p < 60; p++) begin
      hi = int'($urandom_range(1, 60));
      lo = int'($urandom_range(1, 30));
      add(1'b1, hi);
      add(1'b0, lo);
    end
    run_wave("random_mix");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
